// File: rtl/nram_write_arbiter_if.sv
// Request-side handshake bundle for nram_write_arbiter: per-requester valid/addr/data
// in packed slices, plus the one-hot ready returned by the arbiter.
interface nram_write_arbiter_if #(
    parameter int W    = 8,
    parameter int NREQ = 2,
    parameter int AW   = 1
);
    logic [NREQ-1:0]    io_req_valid;
    logic [NREQ*AW-1:0] io_req_addr;
    logic [NREQ*W-1:0]  io_req_data;
    logic [NREQ-1:0]    io_req_ready;

    modport master (
        output io_req_valid,
        output io_req_addr,
        output io_req_data,
        input  io_req_ready
    );

    modport slave (
        input  io_req_valid,
        input  io_req_addr,
        input  io_req_data,
        output io_req_ready
    );
endinterface

// File: rtl/nram_write_arbiter.sv
// Round-robin arbiter sharing the NRAM single write port between NREQ requesters.
// Optional NRAM_WR_COUNT_EN adds per-requester saturating accepted-write counters (io_wr_count).
module nram_write_arbiter #(
    parameter int W    = 8,
    parameter int NREG = 2,
    parameter int NREQ = 2,
    parameter int AW   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    nram_write_arbiter_if.slave       req,
    output logic [W-1:0]              io_Dbus,
    output logic [NREG-1:0]           io_ENbus,
    output logic [$clog2(NREQ)-1:0]   io_grant_id,
    output logic                      io_err,
    input  logic                      io_clr_err
`ifdef NRAM_WR_COUNT_EN
    ,
    output logic [NREQ*8-1:0]         io_wr_count
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [W-1:0]    dbus_q, dbus_d;
    logic [NREG-1:0] en_q,   en_d;
    logic [PW-1:0]   gid_q,  gid_d;
    logic [PW-1:0]   ptr_q,  ptr_d;
    logic            err_q,  err_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] ready;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [W-1:0]    win_data;
    logic            in_range;

    // Search upward from the pointer with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req.io_req_valid[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Nothing is accepted while reset is held, even though the pointer already reads zero.
    assign xfer = found & ~reset;

    always_comb begin
        ready = '0;
        if (xfer) ready[win] = 1'b1;
    end

    assign req.io_req_ready = ready;

    assign win_addr = req.io_req_addr[int'(win)*AW +: AW];
    assign win_data = req.io_req_data[int'(win)*W +: W];
    assign in_range = int'(win_addr) < NREG;

    always_comb begin
        dbus_d = dbus_q;
        en_d   = '0;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        err_d  = err_q & ~io_clr_err;
        if (xfer) begin
            dbus_d = win_data;
            gid_d  = win;
            ptr_d  = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            for (int r = 0; r < NREG; r++) begin
                en_d[r] = in_range && (int'(win_addr) == r);
            end
            // A bad address overrides a simultaneous clear.
            if (!in_range) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            dbus_q <= '0;
            en_q   <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            dbus_q <= dbus_d;
            en_q   <= en_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
        end
    end

    assign io_Dbus     = dbus_q;
    assign io_ENbus    = en_q;
    assign io_grant_id = gid_q;
    assign io_err      = err_q;

`ifdef NRAM_WR_COUNT_EN
    logic [7:0] cnt_q [NREQ];
    logic [7:0] cnt_d [NREQ];

    // Saturating per-requester counts; the clear strobe beats a same-edge increment.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (io_clr_err) begin
                cnt_d[i] = '0;
            end else if (xfer && (win == PW'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it takes the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        io_wr_count = '0;
        for (int i = 0; i < NREQ; i++) io_wr_count[i*8 +: 8] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_nram_write_arbiter.sv
// Self-checking bench for nram_write_arbiter: directed steps followed by a random phase,
// all compared against a behavioural round-robin model.
module tb_nram_write_arbiter;

    localparam int W    = 8;
    localparam int NREG = 3;
    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int PW   = $clog2(NREQ);

    logic clk = 1'b0;
    logic reset;
    logic io_clr_err;
    logic [W-1:0]    io_Dbus;
    logic [NREG-1:0] io_ENbus;
    logic [PW-1:0]   io_grant_id;
    logic            io_err;
`ifdef NRAM_WR_COUNT_EN
    logic [NREQ*8-1:0] io_wr_count;
`endif

    nram_write_arbiter_if #(.W(W), .NREQ(NREQ), .AW(AW)) bus ();

    nram_write_arbiter #(.W(W), .NREG(NREG), .NREQ(NREQ), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.slave),
        .io_Dbus     (io_Dbus),
        .io_ENbus    (io_ENbus),
        .io_grant_id (io_grant_id),
        .io_err      (io_err),
        .io_clr_err  (io_clr_err)
`ifdef NRAM_WR_COUNT_EN
        ,
        .io_wr_count (io_wr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state
    int         m_ptr;
    logic [7:0] m_dbus;
    int         m_en;
    int         m_gid;
    logic       m_err;
    int         m_cnt [NREQ];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input int addr, input logic [7:0] data);
        bus.io_req_valid[i]          = v;
        bus.io_req_addr[i*AW +: AW]  = AW'(addr);
        bus.io_req_data[i*W +: W]    = data;
    endtask

    // Winner = valid requester at the smallest circular distance from the pointer.
    function automatic int exp_winner();
        int best, bestd, d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.io_req_valid[i]) begin
                d = (i - m_ptr + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_dbus = '0;
        m_en   = 0;
        m_gid  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".dbus"}, 64'(io_Dbus), 64'(m_dbus));
        check({tag, ".en"},   64'(io_ENbus), 64'(m_en));
        check({tag, ".gid"},  64'(io_grant_id), 64'(m_gid));
        check({tag, ".err"},  64'(io_err), 64'(m_err));
`ifdef NRAM_WR_COUNT_EN
        for (int i = 0; i < NREQ; i++)
            check({tag, ".cnt"}, 64'(io_wr_count[i*8 +: 8]), 64'(m_cnt[i]));
`endif
    endtask

    // One clock: check combinational ready, take the edge, update the model, check registers.
    task automatic step(input string tag);
        int w, a;
        logic clr;
        #1;
        w = exp_winner();
        check({tag, ".ready"}, 64'(bus.io_req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
        clr = io_clr_err;
        @(posedge clk);
        if (w >= 0) begin
            a      = int'(bus.io_req_addr[w*AW +: AW]);
            m_dbus = bus.io_req_data[w*W +: W];
            m_en   = (a < NREG) ? (1 << a) : 0;
            m_gid  = w;
            m_ptr  = (w + 1) % NREQ;
            m_err  = (m_err && !clr) || (a >= NREG);
        end else begin
            m_en  = 0;
            m_err = m_err && !clr;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (i == w && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst.ready", 64'(bus.io_req_ready), 64'd0);
        check_regs("rst");
        @(posedge clk);
        #1;
        check("rst_hold.ready", 64'(bus.io_req_ready), 64'd0);
        check_regs("rst_hold");
        #2 reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        io_clr_err = 1'b0;
        bus.io_req_valid = '0;
        bus.io_req_addr  = '0;
        bus.io_req_data  = '0;
        #2;

        // 1: reset with both requesters valid
        set_req(0, 1'b1, 0, 8'h11);
        set_req(1, 1'b1, 1, 8'h22);
        do_reset();

        // 2: single write from req0 to register 1
        set_req(1, 1'b0, 0, 8'h00);
        set_req(0, 1'b1, 1, 8'hA5);
        step("single");
        check("single.en_abs", 64'(io_ENbus), 64'h2);
        set_req(0, 1'b0, 1, 8'hA5);
        step("single_idle");

        // 3: contention alternates from req0 after reset
        set_req(0, 1'b1, 0, 8'h11);
        set_req(1, 1'b1, 1, 8'h22);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step("contend");
            check("contend.gid_abs", 64'(io_grant_id), 64'(k % 2));
        end

        // 4: lone req1 regranted, then contention returns to req0
        set_req(0, 1'b0, 0, 8'h11);
        step("lone1");
        check("lone1.gid_abs", 64'(io_grant_id), 64'd1);
        set_req(0, 1'b1, 0, 8'h11);
        step("wrap");
        check("wrap.gid_abs", 64'(io_grant_id), 64'd0);

        // 5: out-of-range write, sticky error, clear, clear-vs-set
        set_req(1, 1'b0, 0, 8'h00);
        set_req(0, 1'b1, 3, 8'h5C);
        step("bad");
        check("bad.err_abs", 64'(io_err), 64'd1);
        set_req(0, 1'b0, 0, 8'h00);
        step("bad_hold");
        step("bad_hold2");
        io_clr_err = 1'b1;
        step("clr");
        io_clr_err = 1'b0;
        check("clr.err_abs", 64'(io_err), 64'd0);
        set_req(1, 1'b1, 3, 8'h77);
        io_clr_err = 1'b1;
        step("clr_vs_set");
        io_clr_err = 1'b0;
        check("clr_vs_set.err_abs", 64'(io_err), 64'd1);
        io_clr_err = 1'b1;
        set_req(1, 1'b0, 0, 8'h00);
        step("clr2");
        io_clr_err = 1'b0;

        // 6: async reset between edges during back-to-back grants
        set_req(0, 1'b1, 2, 8'h31);
        set_req(1, 1'b1, 1, 8'h42);
        step("b2b");
        step("b2b");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async.en", 64'(io_ENbus), 64'd0);
        check("async.ready", 64'(bus.io_req_ready), 64'd0);
        check_regs("async");
        @(posedge clk);
        #2 reset = 1'b0;
        step("post_rst");
        check("post_rst.gid_abs", 64'(io_grant_id), 64'd0);

        // Saturation: 300 writes by req0 alone
        set_req(1, 1'b0, 0, 8'h00);
        for (int k = 0; k < 300; k++) begin
            set_req(0, 1'b1, k % 4, 8'(k));
            step("sat");
        end
`ifdef NRAM_WR_COUNT_EN
        check("sat.cnt0_abs", 64'(io_wr_count[7:0]), 64'd255);
`endif

        // Random phase
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom));
            io_clr_err = ($urandom_range(0, 9) == 0);
            step("rand");
        end
        io_clr_err = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
